wb_port_arbiter: RTL and testbench

//  Shares one register-file writeback port among the execution units assigned to it by a WB_GROUP row.

---
 rtl/wb_port_arbiter_pkg.sv | 26 ++
 rtl/wb_arb_age_tracker.sv | 57 +++++
 rtl/wb_port_arbiter.sv | 118 +++++++++++
 tb/tb_wb_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the writeback-port arbiter.
// The optional starvation guard is enabled with WB_PORT_ARBITER_STARVATION_GUARD_EN.
package wb_port_arbiter_pkg;

    // Upper bounds that the instantiation site must respect.
    localparam int MAX_NUM_UNITS    = 16;
    localparam int MAX_IDS          = 16;
    localparam int MAX_STARVE_LIMIT = 255;

    // Instruction id as carried by a full-size core configuration.
    typedef logic [$clog2(MAX_IDS)-1:0] id_t;

    // Container able to hold any starvation age the guard can be configured for.
    typedef logic [$clog2(MAX_STARVE_LIMIT+1)-1:0] wb_arb_age_t;

    // Request/grant vector at the maximum supported port width.
    typedef logic [MAX_NUM_UNITS-1:0] unit_vec_t;

    // Isolates the lowest set bit: index 0 is the highest-priority requester.
    function automatic unit_vec_t lowest_one(input unit_vec_t req);
        unit_vec_t onehot;
        onehot = req & (~req + unit_vec_t'(1));
        return onehot;
    endfunction

endpackage

// File: rtl/wb_arb_age_tracker.sv
// Starvation age counters for units 1..NUM_UNITS-1 of a writeback port.
// Only instantiated when WB_PORT_ARBITER_STARVATION_GUARD_EN is defined.
// A unit's age counts cycles spent done but not acked; once it reaches
// STARVE_LIMIT the unit is promoted above every non-promoted unit.
module wb_arb_age_tracker
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_UNITS    = 5,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_UNITS-1:1] unit_done,
    input  logic [NUM_UNITS-1:1] unit_ack,
    output logic [NUM_UNITS-1:0] promote
);

    localparam int              AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0]     age_r     [1:NUM_UNITS-1];
    logic [AGE_W-1:0]     age_nxt_s [1:NUM_UNITS-1];
    logic [NUM_UNITS-1:1] promote_r;

    // Next age: clear when idle or served, otherwise count up and saturate.
    always_comb begin
        for (int i = 1; i < NUM_UNITS; i++) begin
            age_nxt_s[i] = age_r[i];
            if (!unit_done[i] || unit_ack[i]) begin
                age_nxt_s[i] = '0;
            end else if (age_r[i] == LIMIT) begin
                age_nxt_s[i] = LIMIT;
            end else begin
                age_nxt_s[i] = age_r[i] + AGE_W'(1);
            end
        end
    end

    // Age registers plus a registered copy of the "age at limit" flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_UNITS; i++) begin
                age_r[i] <= '0;
            end
            promote_r <= '0;
        end else begin
            for (int i = 1; i < NUM_UNITS; i++) begin
                age_r[i]     <= age_nxt_s[i];
                promote_r[i] <= (age_nxt_s[i] == LIMIT);
            end
        end
    end

    // Unit 0 already has top fixed priority, so it is never promoted.
    assign promote = {promote_r, 1'b0};

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: picks one finished execution unit per cycle,
// acks it and captures its id/result in a one-entry output stage.
// Fixed priority, index 0 highest. Defining WB_PORT_ARBITER_STARVATION_GUARD_EN
// adds per-unit age counters that promote long-waiting units.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_UNITS    = 5,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_UNITS-1:0]        unit_done,
    input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_rd,
    output logic [NUM_UNITS-1:0]        unit_ack,
    input  logic                        wb_ready,
    output logic                        wb_valid,
    output logic [ID_W-1:0]             wb_id,
    output logic [DATA_W-1:0]           wb_data
);

    logic                 accept_s;
    logic [NUM_UNITS-1:0] req_s;
    logic [NUM_UNITS-1:0] grant_s;
    logic [ID_W-1:0]      sel_id_s;
    logic [DATA_W-1:0]    sel_data_s;

    logic                 wb_valid_r;
    logic [ID_W-1:0]      wb_id_r;
    logic [DATA_W-1:0]    wb_data_r;

    // The output stage can take a new result when empty or being drained.
    assign accept_s = ~wb_valid_r | wb_ready;

`ifdef WB_PORT_ARBITER_STARVATION_GUARD_EN
    logic [NUM_UNITS-1:0] promote_s;
    logic [NUM_UNITS-1:0] promoted_s;

    generate
        if (NUM_UNITS > 1) begin : g_age
            wb_arb_age_tracker #(
                .NUM_UNITS    (NUM_UNITS),
                .STARVE_LIMIT (STARVE_LIMIT)
            ) u_age (
                .clk       (clk),
                .rst_n     (rst_n),
                .unit_done (unit_done[NUM_UNITS-1:1]),
                .unit_ack  (unit_ack[NUM_UNITS-1:1]),
                .promote   (promote_s)
            );
        end else begin : g_no_age
            assign promote_s = '0;
        end
    endgenerate

    // Promotion is only honoured while the unit still holds a result.
    assign promoted_s = promote_s & unit_done;

    // Promoted units, if any, form the request set; otherwise all done units do.
    always_comb begin
        if (|promoted_s) begin
            req_s = promoted_s;
        end else begin
            req_s = unit_done;
        end
    end
`else
    assign req_s = unit_done;
`endif

    generate
        if (NUM_UNITS == 1) begin : g_single
            assign grant_s = req_s;
        end else begin : g_multi
            assign grant_s = NUM_UNITS'(lowest_one(unit_vec_t'(req_s)));
        end
    endgenerate

    // Acks are only issued when the output stage can take the result.
    assign unit_ack = grant_s & {NUM_UNITS{accept_s}};

    // One-hot mux of the granted unit's id and result.
    always_comb begin
        sel_id_s   = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            sel_id_s   = sel_id_s   | ({ID_W{grant_s[i]}}   & unit_id[i*ID_W +: ID_W]);
            sel_data_s = sel_data_s | ({DATA_W{grant_s[i]}} & unit_rd[i*DATA_W +: DATA_W]);
        end
    end

    // Output stage: reload on accept with a winner, empty on accept without one, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_r <= 1'b0;
            wb_id_r    <= '0;
            wb_data_r  <= '0;
        end else if (accept_s) begin
            if (|unit_done) begin
                wb_valid_r <= 1'b1;
                wb_id_r    <= sel_id_s;
                wb_data_r  <= sel_data_s;
            end else begin
                wb_valid_r <= 1'b0;
            end
        end else begin
            wb_valid_r <= wb_valid_r;
        end
    end

    assign wb_valid = wb_valid_r;
    assign wb_id    = wb_id_r;
    assign wb_data  = wb_data_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (5-unit and 1-unit instances).
// Expected behaviour comes from a cycle-level reference model of the
// arbitration rules; WB_PORT_ARBITER_STARVATION_GUARD_EN selects the guard.
module tb_wb_port_arbiter;

    localparam int STARVE = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   unit_done;
    logic [19:0]  unit_id;
    logic [159:0] unit_rd;
    logic [4:0]   unit_ack;
    logic         wb_ready;
    logic         wb_valid;
    logic [3:0]   wb_id;
    logic [31:0]  wb_data;

    logic         d1_done;
    logic [3:0]   d1_id;
    logic [31:0]  d1_rd;
    logic         d1_ack;
    logic         d1_ready;
    logic         d1_valid;
    logic [3:0]   d1_wid;
    logic [31:0]  d1_wdata;

    wb_port_arbiter #(.NUM_UNITS(5), .DATA_W(32), .ID_W(4), .STARVE_LIMIT(STARVE)) dut5 (
        .clk(clk), .rst_n(rst_n), .unit_done(unit_done), .unit_id(unit_id),
        .unit_rd(unit_rd), .unit_ack(unit_ack), .wb_ready(wb_ready),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data)
    );

    wb_port_arbiter #(.NUM_UNITS(1), .DATA_W(32), .ID_W(4), .STARVE_LIMIT(15)) dut1 (
        .clk(clk), .rst_n(rst_n), .unit_done(d1_done), .unit_id(d1_id),
        .unit_rd(d1_rd), .unit_ack(d1_ack), .wb_ready(d1_ready),
        .wb_valid(d1_valid), .wb_id(d1_wid), .wb_data(d1_wdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Unit-side state: each unit holds one pending result until acked.
    bit          pend  [5];
    logic [3:0]  uid   [5];
    logic [31:0] udata [5];
    int          age   [5];

    // Reference model of the output stage.
    bit          m_valid;
    logic [3:0]  m_id;
    logic [31:0] m_data;
    logic [4:0]  obs_ack;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive units, check acks, clock, check output stage.
    task automatic run_cycle();
        int         win;
        bit         acc;
        logic [4:0] exp_ack;
        for (int i = 0; i < 5; i++) begin
            unit_done[i]         = pend[i];
            unit_id[i*4 +: 4]    = uid[i];
            unit_rd[i*32 +: 32]  = udata[i];
        end
        #2;
        acc = !m_valid || wb_ready;
        win = -1;
`ifdef WB_PORT_ARBITER_STARVATION_GUARD_EN
        for (int i = 1; i < 5; i++) begin
            if (win < 0 && pend[i] && age[i] >= STARVE) win = i;
        end
`endif
        for (int i = 0; i < 5; i++) begin
            if (win < 0 && pend[i]) win = i;
        end
        exp_ack = (acc && win >= 0) ? (5'b00001 << win) : 5'b00000;
        obs_ack = unit_ack;
        check("unit_ack", 64'(unit_ack), 64'(exp_ack));
        @(posedge clk);
        #1;
        if (acc) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_id    = uid[win];
                m_data  = udata[win];
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (pend[i] && !exp_ack[i]) age[i] = (age[i] + 1 > STARVE) ? STARVE : age[i] + 1;
            else age[i] = 0;
            if (exp_ack[i]) pend[i] = 1'b0;
        end
        check("wb_valid", 64'(wb_valid), 64'(m_valid));
        if (m_valid) begin
            check("wb_id", 64'(wb_id), 64'(m_id));
            check("wb_data", 64'(wb_data), 64'(m_data));
        end
    endtask

    task automatic drain();
        wb_ready = 1'b1;
        repeat (8) run_cycle();
    endtask

    // Bound on total run time.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int nacks;
        for (int i = 0; i < 5; i++) begin
            pend[i] = 1'b0; uid[i] = 4'h0; udata[i] = 32'h0; age[i] = 0;
        end
        m_valid = 1'b0; m_id = 4'h0; m_data = 32'h0;
        unit_done = 5'b0; unit_id = 20'h0; unit_rd = 160'h0; wb_ready = 1'b0;
        d1_done = 1'b0; d1_id = 4'h0; d1_rd = 32'h0; d1_ready = 1'b0;

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_id", 64'(wb_id), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_ack", 64'(unit_ack), 64'd0);
        check("rst_d1_valid", 64'(d1_valid), 64'd0);
        check("rst_d1_ack", 64'(d1_ack), 64'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Priority: units 1, 2, 4 done
        wb_ready = 1'b1;
        pend[1] = 1'b1; uid[1] = 4'd1; udata[1] = 32'h1111_0001;
        pend[2] = 1'b1; uid[2] = 4'd2; udata[2] = 32'h2222_0002;
        pend[4] = 1'b1; uid[4] = 4'd4; udata[4] = 32'h4444_0004;
        run_cycle(); check("prio_ack1", 64'(obs_ack), 64'h02);
        run_cycle(); check("prio_ack2", 64'(obs_ack), 64'h04);
        run_cycle(); check("prio_ack4", 64'(obs_ack), 64'h10);
        check("prio_last_id", 64'(wb_id), 64'd4);
        drain();

        // Backpressure: unit0 loaded, then ready low for 3 cycles
        pend[0] = 1'b1; uid[0] = 4'd7; udata[0] = 32'hDEAD_BEEF;
        pend[1] = 1'b1; uid[1] = 4'd9; udata[1] = 32'h0000_0009;
        run_cycle();
        wb_ready = 1'b0;
        repeat (3) run_cycle();
        check("bp_hold_id", 64'(wb_id), 64'd7);
        check("bp_hold_data", 64'(wb_data), 64'hDEAD_BEEF);
        wb_ready = 1'b1;
        run_cycle(); check("bp_release_ack", 64'(obs_ack), 64'h02);
        drain();

        // Back-to-back: unit0 ids 0..9
        nacks = 0;
        for (int k = 0; k < 10; k++) begin
            pend[0] = 1'b1; uid[0] = 4'(k); udata[0] = $urandom;
            run_cycle();
            if (obs_ack[0]) nacks++;
            check("b2b_id", 64'(wb_id), 64'(k));
        end
        check("b2b_acks", 64'(nacks), 64'd10);
        drain();

        // Starvation: unit0 always done, unit2 waiting
        first = 0;
        pend[2] = 1'b1; uid[2] = 4'd5; udata[2] = 32'h5555_5555;
        for (int k = 1; k <= 12; k++) begin
            if (!pend[0]) begin
                pend[0] = 1'b1; uid[0] = 4'(k); udata[0] = $urandom;
            end
            run_cycle();
            if (first == 0 && obs_ack[2]) first = k;
        end
`ifdef WB_PORT_ARBITER_STARVATION_GUARD_EN
        check("starve_ack_cycle", 64'(first), 64'd4);
`else
        check("starve_never_acked", 64'(first), 64'd0);
`endif
        drain();

        // Mid-operation reset with a held result
        wb_ready = 1'b0;
        pend[3] = 1'b1; uid[3] = 4'hA; udata[3] = 32'h0000_1234;
        run_cycle();
        check("pre_rst_valid", 64'(wb_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(wb_valid), 64'd0);
        check("mid_rst_id", 64'(wb_id), 64'd0);
        check("mid_rst_data", 64'(wb_data), 64'd0);
        unit_done = 5'b0;
        #1;
        check("mid_rst_ack", 64'(unit_ack), 64'd0);
        m_valid = 1'b0; m_id = 4'h0; m_data = 32'h0;
        for (int i = 0; i < 5; i++) age[i] = 0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            wb_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < 5; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1; uid[i] = 4'($urandom); udata[i] = $urandom;
                end
            end
            run_cycle();
        end
        drain();
        drain();

        // Single-unit port
        d1_done = 1'b1; d1_id = 4'd3; d1_rd = 32'hCAFE_0003; d1_ready = 1'b1;
        #2;
        check("n1_ack", 64'(d1_ack), 64'd1);
        @(posedge clk);
        #1;
        check("n1_valid", 64'(d1_valid), 64'd1);
        check("n1_id", 64'(d1_wid), 64'd3);
        check("n1_data", 64'(d1_wdata), 64'hCAFE_0003);
        d1_done = 1'b0;
        #2;
        check("n1_idle_ack", 64'(d1_ack), 64'd0);
        @(posedge clk);
        #1;
        check("n1_cleared", 64'(d1_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
